// File: rtl/id_if.sv
// Decode-stage bus: IF_ID inputs, writeback/EX feedback, and the decoded bundle toward ID_EX.
interface id_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 6;
  localparam int unsigned ALU_W  = 4;

  logic [DATA_W-1:0] INSTR_IN;
  logic [DATA_W-1:0] PC_IN;
  logic              flush_IN;
  logic              WB_regWrite_IN;
  logic [REG_AW-1:0] WB_RD_IN;
  logic [DATA_W-1:0] WB_DATA_IN;
  logic              EX_memRead_IN;
  logic [REG_AW-1:0] EX_RD_IN;

  logic [DATA_W-1:0] PC_OUT;
  logic [DATA_W-1:0] RS_OUT;
  logic [DATA_W-1:0] RT_OUT;
  logic [DATA_W-1:0] IMM_OUT;
  logic [REG_AW-1:0] RD_OUT;
  logic              regWrite_OUT;
  logic              memtoReg_OUT;
  logic              PCtoReg_OUT;
  logic              branchN_OUT;
  logic              branchZ_OUT;
  logic              jump_OUT;
  logic              jumpMem_OUT;
  logic              memRead_OUT;
  logic              memWrite_OUT;
  logic [ALU_W-1:0]  ALUop_OUT;
  logic              stall_OUT;

  modport master (
    output INSTR_IN, PC_IN, flush_IN, WB_regWrite_IN, WB_RD_IN, WB_DATA_IN,
           EX_memRead_IN, EX_RD_IN,
    input  PC_OUT, RS_OUT, RT_OUT, IMM_OUT, RD_OUT, regWrite_OUT, memtoReg_OUT,
           PCtoReg_OUT, branchN_OUT, branchZ_OUT, jump_OUT, jumpMem_OUT,
           memRead_OUT, memWrite_OUT, ALUop_OUT, stall_OUT
  );

  modport slave (
    input  INSTR_IN, PC_IN, flush_IN, WB_regWrite_IN, WB_RD_IN, WB_DATA_IN,
           EX_memRead_IN, EX_RD_IN,
    output PC_OUT, RS_OUT, RT_OUT, IMM_OUT, RD_OUT, regWrite_OUT, memtoReg_OUT,
           PCtoReg_OUT, branchN_OUT, branchZ_OUT, jump_OUT, jumpMem_OUT,
           memRead_OUT, memWrite_OUT, ALUop_OUT, stall_OUT
  );
endinterface

// File: rtl/id_stage.sv
// Instruction decode: control decode, 64x32 register file with write-through,
// load-use stall and flush bubbles. Outputs are combinational; ID_EX samples them.
module id_stage (
  input logic clk,
  input logic rst_n,
  id_if.slave bus
);
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_CNT = 64;
  localparam int unsigned REG_AW  = 6;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned IMM_W   = 16;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             pc_to_reg;
    logic             branch_n;
    logic             branch_z;
    logic             jump;
    logic             jump_mem;
    logic             mem_read;
    logic             mem_write;
    logic [ALU_W-1:0] alu_op;
  } ctrl_t;

  logic [DATA_W-1:0] regs [REG_CNT];

  logic [OP_W-1:0]   opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [IMM_W-1:0]  imm;

  ctrl_t ctrl_dec;
  ctrl_t ctrl_out;
  logic  use_rs;
  logic  use_rt;
  logic  hazard;
  logic  kill;

  assign opcode = bus.INSTR_IN[31:28];
  assign rd     = bus.INSTR_IN[27:22];
  assign rs     = bus.INSTR_IN[21:16];
  assign rt     = bus.INSTR_IN[15:10];
  assign imm    = bus.INSTR_IN[15:0];

  // Register file: reset clears every entry and drops a concurrent writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_CNT); i++) begin
        regs[i] <= '0;
      end
    end else if (bus.WB_regWrite_IN) begin
      regs[bus.WB_RD_IN] <= bus.WB_DATA_IN;
    end
  end

  // Write-through so a same-cycle writeback is visible before it commits.
  assign bus.RS_OUT = (rst_n && bus.WB_regWrite_IN && (bus.WB_RD_IN == rs))
                      ? bus.WB_DATA_IN : regs[rs];
  assign bus.RT_OUT = (rst_n && bus.WB_regWrite_IN && (bus.WB_RD_IN == rt))
                      ? bus.WB_DATA_IN : regs[rt];

  // Opcode decode; use_rs/use_rt mark which specifiers are real sources.
  always_comb begin
    ctrl_dec = '0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    unique case (opcode)
      4'b1111: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.pc_to_reg = 1'b1;
        ctrl_dec.alu_op    = 4'b1000;
      end
      4'b1110: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        use_rs              = 1'b1;
      end
      4'b0011: begin
        ctrl_dec.mem_write = 1'b1;
        use_rs             = 1'b1;
        use_rt             = 1'b1;
      end
      4'b0100, 4'b0111: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = opcode;
        use_rs             = 1'b1;
        use_rt             = 1'b1;
      end
      4'b0101, 4'b0110: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = opcode;
        use_rs             = 1'b1;
      end
      4'b1000: begin
        ctrl_dec.jump = 1'b1;
        use_rs        = 1'b1;
      end
      4'b1001: begin
        ctrl_dec.branch_z = 1'b1;
        use_rs            = 1'b1;
      end
      4'b1010: begin
        ctrl_dec.jump_mem = 1'b1;
        ctrl_dec.mem_read = 1'b1;
        use_rs            = 1'b1;
      end
      4'b1011: begin
        ctrl_dec.branch_n = 1'b1;
        use_rs            = 1'b1;
      end
      default: begin
        ctrl_dec = '0;
      end
    endcase
  end

  // Load-use: only specifiers the instruction actually reads can hazard.
  assign hazard = bus.EX_memRead_IN &&
                  ((use_rs && (bus.EX_RD_IN == rs)) || (use_rt && (bus.EX_RD_IN == rt)));

  // Reset and flush dominate; a stall inserts a bubble without touching data.
  assign kill          = !rst_n || bus.flush_IN || hazard;
  assign ctrl_out      = kill ? ctrl_t'('0) : ctrl_dec;
  assign bus.stall_OUT = rst_n && !bus.flush_IN && hazard;

  assign bus.PC_OUT       = bus.PC_IN;
  assign bus.IMM_OUT      = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  assign bus.RD_OUT       = rd;
  assign bus.regWrite_OUT = ctrl_out.reg_write;
  assign bus.memtoReg_OUT = ctrl_out.mem_to_reg;
  assign bus.PCtoReg_OUT  = ctrl_out.pc_to_reg;
  assign bus.branchN_OUT  = ctrl_out.branch_n;
  assign bus.branchZ_OUT  = ctrl_out.branch_z;
  assign bus.jump_OUT     = ctrl_out.jump;
  assign bus.jumpMem_OUT  = ctrl_out.jump_mem;
  assign bus.memRead_OUT  = ctrl_out.mem_read;
  assign bus.memWrite_OUT = ctrl_out.mem_write;
  assign bus.ALUop_OUT    = ctrl_out.alu_op;
endmodule
